mem_stage: RTL and testbench

- Pipeline MEM stage, directly downstream of the EX stage.
- Consumes the EX/MEM pipeline register and performs the data-memory or peripheral access.
- Selects the write-back value and registers the MEM/WB pipeline register.
- Returns that value to EX as MEM_Forward.
- Hosts the memory-mapped timer, LED, digit and systick registers.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/mem_stage_if.sv | 40 ++++
 rtl/data_memory.sv | 25 ++
 rtl/mem_stage.sv | 131 +++++++++++++
 tb/tb_mem_stage.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: write-back select encodings and the peripheral map.
// Pure declarations; no logic, no latency.
// No flow control involved.
package cpu_pkg;

  // Write-back source select carried down the pipe with each instruction
  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;

  // Register offsets inside the 256-byte peripheral window
  localparam logic [7:0] OFF_TH      = 8'h00;
  localparam logic [7:0] OFF_TL      = 8'h04;
  localparam logic [7:0] OFF_TCON    = 8'h08;
  localparam logic [7:0] OFF_LED     = 8'h0C;
  localparam logic [7:0] OFF_DIGI    = 8'h10;
  localparam logic [7:0] OFF_SYSTICK = 8'h14;

  // Default peripheral window; only bits [31:8] take part in the decode
  localparam logic [31:0] PERIPH_BASE_DEF = 32'h4000_0000;

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the MEM stage grouped as one bus.
// Signals only; the MEM/WB side is registered inside mem_stage.
// No backpressure: the stage accepts one instruction every cycle.
interface mem_stage_if;

  logic [31:0] EX_MEM_ALU_OUT;
  logic [31:0] EX_MEM_rt_data;
  logic [31:0] EX_MEM_PC_plus_4;
  logic        EX_MEM_RegWrite;
  logic [4:0]  EX_MEM_WriteAddr;
  logic        EX_MEM_MemRead;
  logic        EX_MEM_MemWrite;
  logic [1:0]  EX_MEM_MemToReg;
  logic        EX_MEM_Forward_MEM;

  logic [31:0] MEM_WB_WriteData;
  logic        MEM_WB_RegWrite;
  logic [4:0]  MEM_WB_WriteAddr;
  logic        MEM_WB_Forward_MEM;
  logic [31:0] MEM_Forward;

  // Upstream side (EX stage / testbench)
  modport master (
    output EX_MEM_ALU_OUT, EX_MEM_rt_data, EX_MEM_PC_plus_4, EX_MEM_RegWrite,
           EX_MEM_WriteAddr, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemToReg,
           EX_MEM_Forward_MEM,
    input  MEM_WB_WriteData, MEM_WB_RegWrite, MEM_WB_WriteAddr,
           MEM_WB_Forward_MEM, MEM_Forward
  );

  // MEM stage side
  modport slave (
    input  EX_MEM_ALU_OUT, EX_MEM_rt_data, EX_MEM_PC_plus_4, EX_MEM_RegWrite,
           EX_MEM_WriteAddr, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemToReg,
           EX_MEM_Forward_MEM,
    output MEM_WB_WriteData, MEM_WB_RegWrite, MEM_WB_WriteAddr,
           MEM_WB_Forward_MEM, MEM_Forward
  );

endinterface

// File: rtl/data_memory.sv
// Word-addressed data RAM, 2^AW x 32, contents not reset.
// Write lands on the clock edge; read is combinational (zero latency).
// No backpressure: one access per cycle, always accepted.
module data_memory #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  // Store the word on the rising edge when enabled
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data memory / peripheral access, write-back select, MEM/WB register.
// One cycle from EX/MEM inputs to MEM/WB outputs; peripheral reads are combinational.
// No backpressure: a new instruction is accepted every cycle.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int          DMEM_AW     = 8,
  parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_stage_if.slave  bus,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irq
);

  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [31:0] systick;

  logic        is_periph;
  logic [7:0]  off;
  logic        dmem_we;
  logic        periph_we;
  logic [31:0] dmem_rdata;
  logic [31:0] periph_rdata;
  logic [31:0] mem_rdata;
  logic [31:0] wb_data;

  // Window decode on the upper address bits; the low byte picks the register
  assign is_periph = (bus.EX_MEM_ALU_OUT[31:8] == PERIPH_BASE[31:8]);
  assign off       = bus.EX_MEM_ALU_OUT[7:0];
  // Gating with rst_n drops a store that is in flight when reset hits
  assign dmem_we   = bus.EX_MEM_MemWrite & ~is_periph & rst_n;
  assign periph_we = bus.EX_MEM_MemWrite & is_periph;

  data_memory #(.AW(DMEM_AW)) u_dmem (
    .clk   (clk),
    .we    (dmem_we),
    .addr  (bus.EX_MEM_ALU_OUT[DMEM_AW+1:2]),
    .wdata (bus.EX_MEM_rt_data),
    .rdata (dmem_rdata)
  );

  // Peripheral read mux; unmapped offsets read as zero
  always_comb begin
    periph_rdata = 32'h0;
    case (off)
      OFF_TH:      periph_rdata = th;
      OFF_TL:      periph_rdata = tl;
      OFF_TCON:    periph_rdata = {29'h0, tcon};
      OFF_LED:     periph_rdata = {24'h0, led};
      OFF_DIGI:    periph_rdata = {20'h0, digi};
      OFF_SYSTICK: periph_rdata = systick;
      default:     periph_rdata = 32'h0;
    endcase
  end

  // Load data, forced to zero when the instruction is not a load
  always_comb begin
    mem_rdata = 32'h0;
    if (bus.EX_MEM_MemRead) begin
      mem_rdata = is_periph ? periph_rdata : dmem_rdata;
    end
  end

  // Write-back source select; the unused 2'b11 code falls back to the ALU value
  always_comb begin
    wb_data = bus.EX_MEM_ALU_OUT;
    case (bus.EX_MEM_MemToReg)
      MTR_MEM: wb_data = mem_rdata;
      MTR_PC4: wb_data = bus.EX_MEM_PC_plus_4;
      default: wb_data = bus.EX_MEM_ALU_OUT;
    endcase
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.MEM_WB_WriteData   <= 32'h0;
      bus.MEM_WB_RegWrite    <= 1'b0;
      bus.MEM_WB_WriteAddr   <= 5'h0;
      bus.MEM_WB_Forward_MEM <= 1'b0;
    end else begin
      bus.MEM_WB_WriteData   <= wb_data;
      bus.MEM_WB_RegWrite    <= bus.EX_MEM_RegWrite;
      bus.MEM_WB_WriteAddr   <= bus.EX_MEM_WriteAddr;
      bus.MEM_WB_Forward_MEM <= bus.EX_MEM_Forward_MEM;
    end
  end

  // Timer, systick and bus writes; the bus write is applied last so it wins a collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      th      <= 32'h0;
      tl      <= 32'h0;
      tcon    <= 3'h0;
      led     <= 8'h0;
      digi    <= 12'h0;
      systick <= 32'h0;
    end else begin
      systick <= systick + 32'd1;
      if (tcon[0]) begin
        if (tl == 32'hFFFF_FFFF) begin
          tl <= th;
          if (tcon[1]) begin
            tcon[2] <= 1'b1;
          end
        end else begin
          tl <= tl + 32'd1;
        end
      end
      if (periph_we) begin
        case (off)
          OFF_TH:   th   <= bus.EX_MEM_rt_data;
          OFF_TL:   tl   <= bus.EX_MEM_rt_data;
          OFF_TCON: tcon <= bus.EX_MEM_rt_data[2:0];
          OFF_LED:  led  <= bus.EX_MEM_rt_data[7:0];
          OFF_DIGI: digi <= bus.EX_MEM_rt_data[11:0];
          default:  ;
        endcase
      end
    end
  end

  assign irq             = tcon[1] & tcon[2];
  assign bus.MEM_Forward = bus.MEM_WB_WriteData;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table through a scoreboard queue,
// then hand-written timer, collision and mid-store reset sequences.
module tb_mem_stage;

  logic        clk;
  logic        rst_n;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irq;

  mem_stage_if bus ();

  mem_stage #(.DMEM_AW(8), .PERIPH_BASE(32'h4000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .led   (led),
    .digi  (digi),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rt;
    logic [31:0] pc4;
    logic        rw;
    logic [4:0]  wa;
    logic        mr;
    logic        mw;
    logic [1:0]  mtr;
    logic        fwd;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        rw;
    logic [4:0]  wa;
    logic        fwd;
  } exp_t;

  localparam logic [31:0] P_TH   = 32'h4000_0000;
  localparam logic [31:0] P_TL   = 32'h4000_0004;
  localparam logic [31:0] P_TCON = 32'h4000_0008;
  localparam logic [31:0] P_LED  = 32'h4000_000C;
  localparam logic [31:0] P_DIGI = 32'h4000_0010;
  localparam logic [31:0] P_TICK = 32'h4000_0014;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t tbl[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] rt,
                              input logic [31:0] pc4, input logic rw, input logic [4:0] wa,
                              input logic mr, input logic mw, input logic [1:0] mtr,
                              input logic fwd, input logic [31:0] exp_data);
    vec_t v;
    v.alu = alu; v.rt = rt; v.pc4 = pc4; v.rw = rw; v.wa = wa;
    v.mr = mr; v.mw = mw; v.mtr = mtr; v.fwd = fwd; v.exp_data = exp_data;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.EX_MEM_ALU_OUT     = v.alu;
    bus.EX_MEM_rt_data     = v.rt;
    bus.EX_MEM_PC_plus_4   = v.pc4;
    bus.EX_MEM_RegWrite    = v.rw;
    bus.EX_MEM_WriteAddr   = v.wa;
    bus.EX_MEM_MemRead     = v.mr;
    bus.EX_MEM_MemWrite    = v.mw;
    bus.EX_MEM_MemToReg    = v.mtr;
    bus.EX_MEM_Forward_MEM = v.fwd;
  endtask

  // Present one instruction, queue its expected MEM/WB contents, compare after the edge
  task automatic step(input string nm, input vec_t v);
    exp_t e;
    drive(v);
    e.data = v.exp_data; e.rw = v.rw; e.wa = v.wa; e.fwd = v.fwd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, ".data"}, bus.MEM_WB_WriteData, e.data);
      chk({nm, ".fwdval"}, bus.MEM_Forward, e.data);
      chk({nm, ".rw"}, {31'h0, bus.MEM_WB_RegWrite}, {31'h0, e.rw});
      chk({nm, ".wa"}, {27'h0, bus.MEM_WB_WriteAddr}, {27'h0, e.wa});
      chk({nm, ".fwdmem"}, {31'h0, bus.MEM_WB_Forward_MEM}, {31'h0, e.fwd});
    end
  endtask

  task automatic wr(input string nm, input logic [31:0] a, input logic [31:0] d);
    step(nm, mk(a, d, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 2'b00, 1'b0, a));
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [4:0] wa,
                    input logic [31:0] exp);
    step(nm, mk(a, 32'h0, 32'h0, 1'b1, wa, 1'b1, 1'b0, 2'b01, 1'b0, exp));
  endtask

  task automatic idle(input string nm);
    step(nm, mk(32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0));
  endtask

  // Hard stop if the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          alu            rt             pc4            rw    wa     mr    mw    mtr    fwd   expected
    tbl[0]  = mk(32'h0000_0010, 32'h1234_5678, 32'h0,         1'b0, 5'd0,  1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0010);
    tbl[1]  = mk(32'h0000_0010, 32'h0,         32'h0,         1'b1, 5'd8,  1'b1, 1'b0, 2'b01, 1'b0, 32'h1234_5678);
    tbl[2]  = mk(32'h0000_0010, 32'h0,         32'h0040_0024, 1'b1, 5'd9,  1'b1, 1'b0, 2'b10, 1'b0, 32'h0040_0024);
    tbl[3]  = mk(32'h0000_0055, 32'h0,         32'h0,         1'b1, 5'd3,  1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0055);
    tbl[4]  = mk(32'h0000_0400, 32'h0000_00A5, 32'h0,         1'b0, 5'd0,  1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0400);
    tbl[5]  = mk(32'h0000_0000, 32'h0,         32'h0,         1'b1, 5'd4,  1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_00A5);
    tbl[6]  = mk(32'h0000_0077, 32'h0,         32'h0,         1'b1, 5'd5,  1'b0, 1'b0, 2'b11, 1'b0, 32'h0000_0077);
    tbl[7]  = mk(32'h0000_0010, 32'h0,         32'h0,         1'b1, 5'd6,  1'b0, 1'b0, 2'b01, 1'b0, 32'h0);
    tbl[8]  = mk(32'h0000_0013, 32'h0,         32'h0,         1'b1, 5'd10, 1'b1, 1'b0, 2'b01, 1'b0, 32'h1234_5678);
    tbl[9]  = mk(P_LED,         32'h0000_01AB, 32'h0,         1'b0, 5'd0,  1'b0, 1'b1, 2'b00, 1'b0, P_LED);
    tbl[10] = mk(P_DIGI,        32'h0000_ABCD, 32'h0,         1'b0, 5'd0,  1'b0, 1'b1, 2'b00, 1'b0, P_DIGI);
    tbl[11] = mk(P_LED,         32'h0,         32'h0,         1'b1, 5'd11, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_00AB);
    tbl[12] = mk(P_DIGI,        32'h0,         32'h0,         1'b1, 5'd12, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0BCD);
    tbl[13] = mk(32'h4000_0030, 32'h5,         32'h0,         1'b0, 5'd0,  1'b0, 1'b1, 2'b00, 1'b0, 32'h4000_0030);
    tbl[14] = mk(32'h4000_0030, 32'h0,         32'h0,         1'b1, 5'd13, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0);
    tbl[15] = mk(32'h4000_010C, 32'h0000_DEAD, 32'h0,         1'b0, 5'd0,  1'b0, 1'b1, 2'b00, 1'b0, 32'h4000_010C);
    tbl[16] = mk(32'h0000_010C, 32'h0,         32'h0,         1'b1, 5'd14, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_DEAD);
    tbl[17] = mk(32'h0000_0011, 32'h0,         32'h0,         1'b1, 5'd31, 1'b0, 1'b0, 2'b00, 1'b1, 32'h0000_0011);
    tbl[18] = mk(32'h0000_0400, 32'h0,         32'h0,         1'b1, 5'd15, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_00A5);

    rst_n = 1'b0;
    drive(mk(32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0));
    #1;
    chk("rst.wbdata", bus.MEM_WB_WriteData, 32'h0);
    chk("rst.rw", {31'h0, bus.MEM_WB_RegWrite}, 32'h0);
    chk("rst.led", {24'h0, led}, 32'h0);
    chk("rst.digi", {20'h0, digi}, 32'h0);
    chk("rst.irq", {31'h0, irq}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      step($sformatf("vec%0d", i), tbl[i]);
    end
    chk("led.value", {24'h0, led}, 32'h0000_00AB);
    chk("digi.value", {20'h0, digi}, 32'h0000_0BCD);

    // Timer reload and interrupt, then acknowledge colliding with a reload
    wr("th", P_TH, 32'hFFFF_FFFE);
    wr("tl", P_TL, 32'hFFFF_FFFE);
    wr("tcon", P_TCON, 32'h3);
    idle("run1");
    chk("irq.before", {31'h0, irq}, 32'h0);
    idle("run2");
    chk("irq.set", {31'h0, irq}, 32'h1);
    rd("tl.reload", P_TL, 5'd1, 32'hFFFF_FFFE);
    wr("tcon.ack", P_TCON, 32'h3);
    chk("irq.ack", {31'h0, irq}, 32'h0);
    rd("tcon.read", P_TCON, 5'd2, 32'h3);

    // Bus write to TL beats the running timer, which then counts on from it
    wr("tl.coll", P_TL, 32'h10);
    rd("tl.after", P_TL, 5'd3, 32'h10);
    rd("tl.next", P_TL, 5'd3, 32'h11);
    wr("tcon.off", P_TCON, 32'h0);

    // Reset asserted in the middle of a store to led
    drive(mk(P_LED, 32'hFF, 32'h0, 1'b1, 5'd5, 1'b0, 1'b1, 2'b00, 1'b0, P_LED));
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid.led", {24'h0, led}, 32'h0);
    chk("mid.rw", {31'h0, bus.MEM_WB_RegWrite}, 32'h0);
    chk("mid.wbdata", bus.MEM_WB_WriteData, 32'h0);
    chk("mid.digi", {20'h0, digi}, 32'h0);
    chk("mid.irq", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #1;
    chk("mid.led.hold", {24'h0, led}, 32'h0);
    rst_n = 1'b1;
    rd("tick0", P_TICK, 5'd6, 32'h0);
    wr("tick.wr", P_TICK, 32'h999);
    rd("tick2", P_TICK, 5'd6, 32'h2);
    rd("tl.rst", P_TL, 5'd7, 32'h0);
    rd("tcon.rst", P_TCON, 5'd7, 32'h0);
    rd("dmem.keep", 32'h0000_0010, 5'd8, 32'h1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
